// File: rtl/fk33_hbm_axi_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fk33_axi_pkg
// Description : Shared AXI4 encodings and FSM state types for the FK33 HBM
//               pseudo-channel responder.
// Revision    : 1.0 - initial release
// ============================================================================
package fk33_axi_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_t;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } axi_burst_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_FETCH = 2'd1,
    R_DATA  = 2'd2
  } rd_state_t;

  // Only full-width INCR bursts are serviced; anything else is answered with SLVERR.
  function automatic logic cfg_bad(input logic [2:0] size, input logic [1:0] burst,
                                   input logic [2:0] full_size);
    return (size != full_size) || (burst != BURST_INCR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fk33_hbm_axi_responder_bram.sv
`default_nettype none
// ============================================================================
// Module      : fk33_hbm_bram
// Description : Simple dual-port RAM. Port A writes with byte enables, port B
//               is a registered one-cycle read that returns the old word when
//               both ports hit the same address in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module fk33_hbm_bram #(
  parameter int DEPTH  = 4096,
  parameter int DATA_W = 256,
  parameter int ADDR_W = 12
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_W-1:0]     i_waddr,
  input  logic [DATA_W-1:0]     i_wdata,
  input  logic [DATA_W/8-1:0]   i_wbe,
  input  logic                  i_re,
  input  logic [ADDR_W-1:0]     i_raddr,
  output logic [DATA_W-1:0]     o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Byte-masked write and enabled read; both sample the array before the edge (read-first).
  always_ff @(posedge clk) begin
    for (int b = 0; b < DATA_W/8; b++) begin
      if (i_we && i_wbe[b]) begin
        r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/fk33_hbm_axi_responder.sv
`default_nettype none
// ============================================================================
// Module      : fk33_hbm_axi_responder
// Description : AXI4 slave modelling one FK33 HBM2 pseudo-channel in BRAM.
//               Single outstanding INCR burst per direction, byte strobes,
//               OKAY/SLVERR responses.
// Revision    : 1.0 - initial release
// ============================================================================
module fk33_hbm_axi_responder
  import fk33_axi_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH  = 34,
  parameter int AXI_DATA_WIDTH  = 256,
  parameter int AXI_ID_WIDTH    = 6,
  parameter int MEM_DEPTH_BEATS = 4096
) (
  input  logic                        clk_hbm,
  input  logic                        rst,
  input  logic [AXI_ID_WIDTH-1:0]     s_axi_awid,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]                  s_axi_awlen,
  input  logic [2:0]                  s_axi_awsize,
  input  logic [1:0]                  s_axi_awburst,
  input  logic                        s_axi_awvalid,
  output logic                        s_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                        s_axi_wlast,
  input  logic                        s_axi_wvalid,
  output logic                        s_axi_wready,
  output logic [AXI_ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]                  s_axi_bresp,
  output logic                        s_axi_bvalid,
  input  logic                        s_axi_bready,
  input  logic [AXI_ID_WIDTH-1:0]     s_axi_arid,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]                  s_axi_arlen,
  input  logic [2:0]                  s_axi_arsize,
  input  logic [1:0]                  s_axi_arburst,
  input  logic                        s_axi_arvalid,
  output logic                        s_axi_arready,
  output logic [AXI_ID_WIDTH-1:0]     s_axi_rid,
  output logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                  s_axi_rresp,
  output logic                        s_axi_rlast,
  output logic                        s_axi_rvalid,
  input  logic                        s_axi_rready
);

  localparam int SIZE_LOG2 = $clog2(AXI_DATA_WIDTH/8);
  localparam int BEAT_W    = AXI_ADDR_WIDTH - SIZE_LOG2;
  localparam int MEM_AW    = $clog2(MEM_DEPTH_BEATS);
  localparam logic [2:0]      C_FULL_SIZE = 3'(SIZE_LOG2);
  // Beat indices carry one spare bit so a burst near the top of the address space cannot wrap.
  localparam logic [BEAT_W:0] C_BEAT_ONE  = 1;

  // ---------------- write channel ----------------
  wr_state_t             r_wstate, w_wstate_nxt;
  logic [AXI_ID_WIDTH-1:0] r_bid;
  logic [BEAT_W:0]       r_wbeat;
  logic [7:0]            r_wcnt, r_wlen;
  logic                  r_wbad, r_werr;
  logic                  w_awready, w_wready, w_bvalid;
  logic                  w_aw_hs, w_w_hs, w_w_final, w_w_oor, w_ram_we;

  // Write FSM next state and handshake readies.
  always_comb begin
    w_wstate_nxt = r_wstate;
    w_awready    = 1'b0;
    w_wready     = 1'b0;
    w_bvalid     = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        w_awready = !rst;
        if (s_axi_awvalid && !rst) w_wstate_nxt = W_DATA;
      end
      W_DATA: begin
        w_wready = 1'b1;
        if (s_axi_wvalid && (r_wcnt == r_wlen)) w_wstate_nxt = W_RESP;
      end
      W_RESP: begin
        w_bvalid = 1'b1;
        if (s_axi_bready) w_wstate_nxt = W_IDLE;
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  assign w_aw_hs   = s_axi_awvalid && w_awready;
  assign w_w_hs    = s_axi_wvalid && w_wready;
  assign w_w_final = (r_wcnt == r_wlen);
  assign w_w_oor   = |r_wbeat[BEAT_W:MEM_AW];
  assign w_ram_we  = w_w_hs && !r_wbad && !w_w_oor;

  // Write FSM state register.
  always_ff @(posedge clk_hbm or posedge rst) begin
    if (rst) r_wstate <= W_IDLE;
    else     r_wstate <= w_wstate_nxt;
  end

  // Latch the AW command, advance the beat pointer and accumulate the burst error.
  always_ff @(posedge clk_hbm or posedge rst) begin
    if (rst) begin
      r_bid   <= '0;
      r_wbeat <= '0;
      r_wcnt  <= '0;
      r_wlen  <= '0;
      r_wbad  <= 1'b0;
      r_werr  <= 1'b0;
    end else if (w_aw_hs) begin
      r_bid   <= s_axi_awid;
      r_wbeat <= {1'b0, s_axi_awaddr[AXI_ADDR_WIDTH-1:SIZE_LOG2]};
      r_wlen  <= s_axi_awlen;
      r_wcnt  <= '0;
      r_wbad  <= cfg_bad(s_axi_awsize, s_axi_awburst, C_FULL_SIZE);
      r_werr  <= cfg_bad(s_axi_awsize, s_axi_awburst, C_FULL_SIZE);
    end else if (w_w_hs) begin
      r_wbeat <= r_wbeat + C_BEAT_ONE;
      r_wcnt  <= r_wcnt + 8'd1;
      if (w_w_oor || (s_axi_wlast != w_w_final)) r_werr <= 1'b1;
    end
  end

  assign s_axi_awready = w_awready;
  assign s_axi_wready  = w_wready;
  assign s_axi_bvalid  = w_bvalid;
  assign s_axi_bid     = r_bid;
  assign s_axi_bresp   = (w_bvalid && r_werr) ? RESP_SLVERR : RESP_OKAY;

  // ---------------- read channel ----------------
  rd_state_t             r_rstate, w_rstate_nxt;
  logic [AXI_ID_WIDTH-1:0] r_rid;
  logic [BEAT_W:0]       r_rbeat;
  logic [7:0]            r_rcnt, r_rlen;
  logic                  r_rbad;
  logic                  w_arready, w_rvalid, w_ar_hs, w_r_hs, w_r_last, w_r_err;
  logic [AXI_DATA_WIDTH-1:0] w_ram_q;

  assign w_r_last = (r_rcnt == r_rlen);

  // Read FSM next state: one fetch cycle ahead of every data beat.
  always_comb begin
    w_rstate_nxt = r_rstate;
    w_arready    = 1'b0;
    w_rvalid     = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        w_arready = !rst;
        if (s_axi_arvalid && !rst) w_rstate_nxt = R_FETCH;
      end
      R_FETCH: w_rstate_nxt = R_DATA;
      R_DATA: begin
        w_rvalid = 1'b1;
        if (s_axi_rready) w_rstate_nxt = w_r_last ? R_IDLE : R_FETCH;
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  assign w_ar_hs = s_axi_arvalid && w_arready;
  assign w_r_hs  = w_rvalid && s_axi_rready;
  assign w_r_err = r_rbad || (|r_rbeat[BEAT_W:MEM_AW]);

  // Read FSM state register.
  always_ff @(posedge clk_hbm or posedge rst) begin
    if (rst) r_rstate <= R_IDLE;
    else     r_rstate <= w_rstate_nxt;
  end

  // Latch the AR command and step to the next beat on each accepted R transfer.
  always_ff @(posedge clk_hbm or posedge rst) begin
    if (rst) begin
      r_rid   <= '0;
      r_rbeat <= '0;
      r_rcnt  <= '0;
      r_rlen  <= '0;
      r_rbad  <= 1'b0;
    end else if (w_ar_hs) begin
      r_rid   <= s_axi_arid;
      r_rbeat <= {1'b0, s_axi_araddr[AXI_ADDR_WIDTH-1:SIZE_LOG2]};
      r_rlen  <= s_axi_arlen;
      r_rcnt  <= '0;
      r_rbad  <= cfg_bad(s_axi_arsize, s_axi_arburst, C_FULL_SIZE);
    end else if (w_r_hs) begin
      r_rbeat <= r_rbeat + C_BEAT_ONE;
      r_rcnt  <= r_rcnt + 8'd1;
    end
  end

  // The RAM output register only reloads in R_FETCH, which keeps rdata stable under stall.
  fk33_hbm_bram #(
    .DEPTH  (MEM_DEPTH_BEATS),
    .DATA_W (AXI_DATA_WIDTH),
    .ADDR_W (MEM_AW)
  ) u_bram (
    .clk     (clk_hbm),
    .i_we    (w_ram_we),
    .i_waddr (r_wbeat[MEM_AW-1:0]),
    .i_wdata (s_axi_wdata),
    .i_wbe   (s_axi_wstrb),
    .i_re    (r_rstate == R_FETCH),
    .i_raddr (r_rbeat[MEM_AW-1:0]),
    .o_rdata (w_ram_q)
  );

  assign s_axi_arready = w_arready;
  assign s_axi_rvalid  = w_rvalid;
  assign s_axi_rid     = r_rid;
  assign s_axi_rdata   = (w_rvalid && !w_r_err) ? w_ram_q : '0;
  assign s_axi_rresp   = (w_rvalid && w_r_err) ? RESP_SLVERR : RESP_OKAY;
  assign s_axi_rlast   = w_rvalid && w_r_last;

  // Sub-beat address bits select nothing in a full-width memory.
  logic w_unused;
  assign w_unused = ^{s_axi_awaddr[SIZE_LOG2-1:0], s_axi_araddr[SIZE_LOG2-1:0]};

endmodule
`default_nettype wire
